// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master system-bus arbiter.
// FSM state codes and master IDs used by the arbiter and its round-robin picker.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin chooser: zero latency, no backpressure.
// On a conflict the master that did not hold the bus last is picked.
module arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       owner,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |reqs;
        grant_id    = ARB_M0;
        if (reqs == 2'b11) begin
            grant_id = ~owner;
        end else if (reqs[1]) begin
            grant_id = ARB_M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: done 2 cycles after grant for writes, RD_LAT+1 for reads.
// Masters are held off by keeping req high until their one-cycle done pulse.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    input  logic        m0_flush,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lat_we;
    logic [31:0]      lat_addr, lat_wdata, rdata_q;
    logic [3:0]       lat_byteen;
    logic             grant_valid, grant_id;
    logic             take, capture;
    logic             flush_own;

    // A flush in IDLE suppresses the CPU request for that cycle only.
    arb_rr_pick u_pick (
        .reqs        ({m1_req, m0_req & ~m0_flush}),
        .owner       (owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign flush_own = m0_flush && (owner == ARB_M0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    take      = 1'b1;
                    state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (lat_we) begin
                    state_nxt = ARB_DONE;
                end else if (flush_own) begin
                    state_nxt = ARB_IDLE;
                end else if (RD_LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = ARB_DONE;
                end else begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (flush_own) begin
                    cnt_nxt   = '0;
                    state_nxt = ARB_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        capture   = 1'b1;
                        state_nxt = ARB_DONE;
                    end
                end
            end
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            owner      <= ARB_M1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_byteen <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                owner      <= grant_id;
                lat_we     <= (grant_id == ARB_M1) ? m1_we     : m0_we;
                lat_addr   <= (grant_id == ARB_M1) ? m1_addr   : m0_addr;
                lat_wdata  <= (grant_id == ARB_M1) ? m1_wdata  : m0_wdata;
                lat_byteen <= (grant_id == ARB_M1) ? m1_byteen : m0_byteen;
                rdata_q    <= '0;
            end
            if (capture) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_addr   = lat_addr;
    assign bus_wdata  = lat_wdata;
    assign bus_byteen = (state == ARB_ACCESS && lat_we) ? lat_byteen : 4'h0;
    assign busy       = (state != ARB_IDLE);
    assign m0_done    = (state == ARB_DONE) && (owner == ARB_M0);
    assign m1_done    = (state == ARB_DONE) && (owner == ARB_M1);
    assign m0_rdata   = m0_done ? rdata_q : 32'h0;
    assign m1_rdata   = m1_done ? rdata_q : 32'h0;

endmodule
